bypass_register_file: RTL and testbench

//  Parametrised architectural register file for the pipelined RV32 core.

---
 rtl/bypass_register_file.sv | 67 ++++++
 tb/tb_bypass_register_file.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bypass_register_file.sv
// bypass_register_file: RV32 register file with write-to-read bypass and an ECALL halt sequencer
module bypass_register_file #(
   parameter int XLEN           = 32,
   parameter int NUM_REGS       = 32,
   parameter int NUM_READ_PORTS = 2,
   parameter int SP_REG         = 2,
   parameter int SP_INIT        = 'h2ffc,
   parameter int HALT_REG       = 17,
   parameter int HALT_VAL       = 10,
   parameter int DRAIN_CYCLES   = 4,
   localparam int AW            = $clog2(NUM_REGS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_READ_PORTS*AW-1:0]   rs_addr,
   output logic [NUM_READ_PORTS*XLEN-1:0] rs_dout,
   input  logic [AW-1:0]                  rd,
   input  logic [XLEN-1:0]                rd_din,
   input  logic                           write_enable,
   input  logic                           is_ecall,
   output logic                           halt_pending,
   output logic                           is_halted
);
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
   state_t state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic [XLEN-1:0] rf [NUM_REGS];
   logic [XLEN-1:0] hv;
   logic wr_ok;
   assign wr_ok = write_enable && rd != '0 && state != HALTED;
   for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_rd
      logic [AW-1:0] a;
      assign a = rs_addr[k*AW +: AW];
      assign rs_dout[k*XLEN +: XLEN] = a == '0 ? '0 : (wr_ok && rd == a) ? rd_din : rf[a];
   end
   // the halt check sees the same forwarded value a read port would
   assign hv = (wr_ok && rd == AW'(HALT_REG)) ? rd_din : rf[AW'(HALT_REG)];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= i == SP_REG ? XLEN'(SP_INIT) : '0;
      end else if (wr_ok) begin
         rf[rd] <= rd_din;
      end
   end
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      if (state == RUN && is_ecall && hv == XLEN'(HALT_VAL)) begin
         state_nx = DRAIN_CYCLES == 0 ? HALTED : DRAIN;
         cnt_nx = 4'(DRAIN_CYCLES);
      end else if (state == DRAIN) begin
         cnt_nx = cnt - 4'd1;
         state_nx = cnt == 4'd1 ? HALTED : DRAIN;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
      end
   end
   assign halt_pending = state == DRAIN;
   assign is_halted = state == HALTED;
endmodule

// File: tb/tb_bypass_register_file.sv
// tb_bypass_register_file: directed and random checks against an array-based reference model
module tb_bypass_register_file;
   localparam int XLEN = 32, NR = 32, NP = 2, AW = 5, DC = 4;
   logic clk = 0, reset = 0;
   logic [NP*AW-1:0] rs_addr;
   logic [NP*XLEN-1:0] rs_dout;
   logic [AW-1:0] rd;
   logic [XLEN-1:0] rd_din;
   logic write_enable, is_ecall, halt_pending, is_halted;
   int checks = 0, errors = 0;
   logic [31:0] m [NR];
   bit halted;
   int drain;

   bypass_register_file dut (
      .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_dout(rs_dout), .rd(rd), .rd_din(rd_din),
      .write_enable(write_enable), .is_ecall(is_ecall), .halt_pending(halt_pending), .is_halted(is_halted)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_rd(int a);
      if (a == 0) return 0;
      if (write_enable && int'(rd) == a && !halted) return rd_din;
      return m[a];
   endfunction

   task automatic check_now(string tag);
      for (int k = 0; k < NP; k++)
         chk($sformatf("%s_p%0d", tag, k), rs_dout[k*XLEN +: XLEN], ref_rd(int'(rs_addr[k*AW +: AW])));
      chk({tag, "_pend"}, 32'(halt_pending), 32'(drain > 0));
      chk({tag, "_halt"}, 32'(is_halted), 32'(halted));
   endtask

   task automatic cycle(string tag, bit we, int r, logic [31:0] d, int a0, int a1, bit ec);
      logic [31:0] hv;
      bit wr;
      write_enable = we; rd = AW'(r); rd_din = d; rs_addr = {AW'(a1), AW'(a0)}; is_ecall = ec;
      #1 check_now(tag);
      hv = ref_rd(17);
      wr = we && r != 0 && !halted;
      if (drain > 0) begin
         drain--;
         if (drain == 0) halted = 1;
      end else if (!halted && ec && hv == 10) begin
         if (DC == 0) halted = 1;
         else drain = DC;
      end
      if (wr) m[r] = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(string tag);
      reset = 1; write_enable = 0; is_ecall = 0;
      foreach (m[i]) m[i] = 0;
      m[2] = 32'h2ffc; halted = 0; drain = 0;
      rs_addr = {AW'(0), AW'(2)};
      #1 check_now({tag, "_a"});
      chk({tag, "_sp"}, rs_dout[31:0], 32'h2ffc);
      rs_addr = {AW'(31), AW'(1)};
      #1 check_now({tag, "_b"});
      @(negedge clk);
      reset = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ec, we;
      int r, a0, a1;
      logic [31:0] d;
      write_enable = 0; is_ecall = 0; rd = 0; rd_din = 0; rs_addr = 0;
      #2 do_reset("t1");
      write_enable = 1; rd = 5; rd_din = 32'hdeadbeef; rs_addr = {AW'(0), AW'(5)};
      #1 chk("t2_bypass", rs_dout[31:0], 32'hdeadbeef);
      cycle("t2_wr", 1, 5, 32'hdeadbeef, 5, 0, 0);
      cycle("t2_r0w", 1, 0, 7, 5, 0, 0);
      write_enable = 0; rs_addr = {AW'(0), AW'(5)};
      #1 chk("t2_keep", rs_dout[31:0], 32'hdeadbeef);
      chk("t2_r0", rs_dout[63:32], 0);
      cycle("t4_w", 1, 17, 9, 17, 0, 0);
      cycle("t4_e", 0, 0, 0, 17, 0, 1);
      repeat (3) cycle("t4_run", 0, 0, 0, 17, 1, 0);
      chk("t4_pend", 32'(halt_pending), 0);
      chk("t4_halt", 32'(is_halted), 0);
      cycle("t3_w", 1, 17, 10, 17, 0, 0);
      cycle("t3_e", 0, 0, 0, 17, 2, 1);
      for (int i = 0; i < DC; i++) begin
         chk("t3_pend", 32'(halt_pending), 1);
         chk("t3_nohalt", 32'(is_halted), 0);
         cycle("t3_d", 0, 0, 0, 17, 2, 0);
      end
      chk("t3_halted", 32'(is_halted), 1);
      chk("t3_pend_off", 32'(halt_pending), 0);
      for (int i = 0; i < 20; i++) cycle("t3_h", 0, 0, 0, 17, 5, i[0]);
      cycle("t6_lock", 1, 6, 32'h55, 6, 6, 0);
      rs_addr = {AW'(6), AW'(6)};
      #1 chk("t6_x6", rs_dout[31:0], 0);
      chk("t6_halted", 32'(is_halted), 1);
      do_reset("t5r");
      cycle("t5_z", 1, 17, 0, 17, 0, 0);
      cycle("t5_f", 1, 17, 10, 17, 0, 1);
      chk("t5_pend", 32'(halt_pending), 1);
      write_enable = 0; rs_addr = {AW'(0), AW'(17)};
      #1 chk("t5_x17", rs_dout[31:0], 10);
      cycle("t6_d1", 0, 0, 0, 17, 2, 0);
      cycle("t6_d2", 0, 0, 0, 17, 2, 0);
      chk("t6_mid", 32'(halt_pending), 1);
      do_reset("t6");
      chk("t6_pend_clr", 32'(halt_pending), 0);
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 60) == 0) do_reset("rrst");
         else begin
            ec = $urandom_range(0, 7) == 0;
            we = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 3) == 0 ? 17 : int'($urandom_range(0, 31));
            d = $urandom_range(0, 1) == 0 ? 32'($urandom_range(8, 11)) : $urandom;
            a0 = $urandom_range(0, 3) == 0 ? r : int'($urandom_range(0, 31));
            a1 = $urandom_range(0, 3) == 0 ? a0 : int'($urandom_range(0, 31));
            cycle("rnd", we, r, d, a0, a1, ec);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
